sorter_seq: RTL and testbench

- Sequencing controller for the 8-input combinational byte sorter (inputs a0..a7, outputs y0..y7; y0 is the minimum and y7 the maximum).
- Collects 8 bytes from a valid/ready input stream into an operand register bank, drives the sorter, and waits a fixed settle time.
- Captures the sorted result, then streams it out with valid/ready in ascending or descending order.
- Sits between a byte-stream producer and consumer; the sorter instance is external and connected through the sort_a/sort_y buses.

---
 rtl/sorter_pkg.sv | 20 ++
 rtl/sorter_seq.sv | 147 ++++++++++++++
 tb/tb_sorter_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared types and constants for the byte sorter sequencer
//
// Purpose: common byte type, sequencer state encoding, element count and
// output-direction constants used by sorter_seq and its environment.
package sorter_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } seq_state_t;

  localparam int N_ELEM = 8;

  localparam logic ASC  = 1'b0;
  localparam logic DESC = 1'b1;

endpackage

// File: rtl/sorter_seq.sv
// rtl/sorter_seq.sv - sequencing controller around an external 8-input byte sorter
//
// Purpose: fills an 8-byte operand bank from a valid/ready input stream,
// presents it to the external combinational sorter, waits SETTLE_CYC cycles,
// captures the sorted result and streams it out ascending or descending.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort, back to IDLE, held data discarded
//   dir        output order (0 ascending, 1 descending), sampled on 8th accept
//   in_valid   input byte valid
//   in_ready   controller accepts an input byte (IDLE only)
//   in_data    input byte
//   sort_a     operand bank to sorter, byte i at [8i+7:8i]
//   sort_y     sorter result, byte i at [8i+7:8i], y0 smallest
//   out_valid  output byte valid
//   out_ready  consumer accepts an output byte
//   out_data   output byte
//   out_last   marks the 8th output byte
//   busy       block in progress or partial fill held
module sorter_seq
  import sorter_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int N          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        dir,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [63:0] sort_a,
  input  logic [63:0] sort_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  // The sorter is hard-wired to 8 lanes and the settle counter is 4 bits.
  if (N != N_ELEM) begin : g_bad_n
    $error("sorter_seq: N must equal 8");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("sorter_seq: SETTLE_CYC must be in 1..15");
  end

  seq_state_t state, state_nxt;

  byte_t      bank [N_ELEM];
  byte_t      res  [N_ELEM];
  logic [2:0] wr_idx;
  logic [2:0] rd_idx;
  logic       dir_q;
  logic [3:0] settle_cnt;

  logic       in_acc;
  logic       out_acc;
  logic [2:0] first_idx;
  logic [2:0] last_idx;

  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  assign first_idx = (dir_q == DESC) ? 3'd7 : 3'd0;
  assign last_idx  = (dir_q == ASC)  ? 3'd7 : 3'd0;

  // Bank feeds the sorter directly; it only moves on IDLE accepts, so the
  // sorter input is frozen from the 8th accept until the next fill.
  for (genvar i = 0; i < N_ELEM; i++) begin : g_pack
    assign sort_a[8*i +: 8] = bank[i];
  end

  // res and rd_idx are both registers, so this mux is stable under stall.
  assign out_data = res[rd_idx];
  assign out_last = (state == DRAIN) && (rd_idx == last_idx);
  assign busy     = (state != IDLE) || (wr_idx != 3'd0);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (wr_idx == 3'd7)) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= 3'd0;
      rd_idx     <= 3'd0;
      dir_q      <= 1'b0;
      settle_cnt <= 4'd0;
      for (int i = 0; i < N_ELEM; i++) begin
        bank[i] <= 8'h00;
        res[i]  <= 8'h00;
      end
    end else if (flush) begin
      // Bank is left as-is; the next fill overwrites every lane.
      wr_idx <= 3'd0;
      rd_idx <= 3'd0;
    end else begin
      if (in_acc) begin
        bank[wr_idx] <= in_data;
        if (wr_idx == 3'd7) begin
          dir_q      <= dir;
          settle_cnt <= 4'(SETTLE_CYC - 1);
          wr_idx     <= 3'd0;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end
      if (state == SETTLE) begin
        if (settle_cnt == 4'd0) begin
          for (int i = 0; i < N_ELEM; i++) res[i] <= sort_y[8*i +: 8];
          rd_idx <= first_idx;
        end else begin
          settle_cnt <= settle_cnt - 4'd1;
        end
      end
      if (out_acc) begin
        rd_idx <= (dir_q == DESC) ? (rd_idx - 3'd1) : (rd_idx + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_sorter_seq.sv
// tb/tb_sorter_seq.sv - self-checking bench for sorter_seq with a behavioural sorter
module tb_sorter_seq;
  import sorter_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dir = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [63:0] sort_a;
  logic [63:0] sort_y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  sorter_seq #(.SETTLE_CYC(S), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dir(dir),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sort_a(sort_a), .sort_y(sort_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational sorter.
  function automatic logic [63:0] sort8(input logic [63:0] a);
    byte_t v [8];
    byte_t t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) v[i] = a[8*i +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[i];
    return r;
  endfunction

  assign sort_y = sort8(sort_a);

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_out = 0;
  int rmode = 0;
  bit pending = 1'b0;
  bit seen_first = 1'b1;
  bit hold_v = 1'b0;
  logic [7:0] hold_d;
  logic hold_l;
  logic [7:0] exp_d [$];
  bit exp_l [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sort_a"}, sort_a, 64'h0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'h1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    check({tag, "_out_last"}, 64'(out_last), 64'h0);
    check({tag, "_out_data"}, 64'(out_data), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  // Consumer ready pattern, driven just after each active edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", 64'(out_valid), 64'h1);
        check("stall_data", 64'(out_data), 64'(hold_d));
        check("stall_last", 64'(out_last), 64'(hold_l));
      end
      hold_v = 1'b0;
      if (pending && (cyc > acc_cyc)) check("in_ready_low_in_block", 64'(in_ready), 64'h0);
      if (out_valid) begin
        if (pending && !seen_first) begin
          check("first_valid_latency", 64'(cyc), 64'(acc_cyc + S + 1));
          seen_first = 1'b1;
        end
        if (out_ready) begin
          n_out++;
          if (exp_d.size() == 0) begin
            fail("output_with_empty_scoreboard");
          end else begin
            logic [7:0] ed;
            bit el;
            ed = exp_d.pop_front();
            el = exp_l.pop_front();
            check("out_data", 64'(out_data), 64'(ed));
            check("out_last", 64'(out_last), 64'(el));
            if (el) pending = 1'b0;
          end
        end else begin
          hold_v = 1'b1;
          hold_d = out_data;
          hold_l = out_last;
        end
      end
    end
  end

  // Sends nb bytes of d (byte 0 first); dir is inverted except on the 8th
  // byte so a wrongly timed dir sample shows up as a reversed block.
  task automatic send_block(input logic [63:0] d, input logic dv, input int gap, input int nb);
    logic [7:0] q [$];
    int w;
    for (int i = 0; i < nb; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d[8*i +: 8];
      dir      = (i == 7) ? dv : ~dv;
      w = 0;
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) fail("in_ready_timeout");
      if (i == 7) begin
        q.delete();
        for (int k = 0; k < 8; k++) q.push_back(d[8*k +: 8]);
        if (dv) q.rsort();
        else    q.sort();
        for (int k = 0; k < 8; k++) begin
          exp_d.push_back(q[k]);
          exp_l.push_back(k == 7);
        end
        acc_cyc    = cyc;
        seen_first = 1'b0;
        pending    = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while ((pending || busy) && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) fail("block_completion_timeout");
  endtask

  localparam logic [63:0] DATA_A = 64'h04_06_02_08_01_07_03_05;
  localparam logic [63:0] DATA_B = 64'h81_7F_80_80_00_FF_00_FF;

  initial begin
    int base;
    int w;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    #2 rst_n = 1'b1;

    rmode = 0;
    send_block(DATA_A, 1'b0, 0, 8);
    wait_done();
    send_block(DATA_A, 1'b1, 0, 8);
    wait_done();

    rmode = 1;
    send_block(DATA_B, 1'b0, 0, 8);
    wait_done();

    rmode = 0;
    send_block(DATA_A, 1'b0, 2, 8);
    wait_done();

    // Abort a partial fill; an accept offered alongside flush is dropped.
    send_block(DATA_A, 1'b0, 0, 5);
    check("busy_partial_fill", 64'(busy), 64'h1);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_flush", 64'(busy), 64'h0);
    check("in_ready_after_flush", 64'(in_ready), 64'h1);
    send_block(64'h11_11_11_11_11_11_11_11, 1'b1, 0, 8);
    wait_done();

    rmode = 2;
    for (int b = 0; b < 6; b++) begin
      logic [63:0] rd;
      rd = {$urandom, $urandom};
      if (b == 3) rd = rd & 64'h0303_0303_0303_0303;
      send_block(rd, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 8);
      wait_done();
    end

    // Asynchronous reset in the middle of a drain.
    rmode = 0;
    base = n_out;
    send_block(DATA_A, 1'b0, 0, 8);
    w = 0;
    while (n_out < base + 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) fail("drain_progress_timeout");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("mid_drain_reset");
    exp_d.delete();
    exp_l.delete();
    pending = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    send_block(DATA_B, 1'b1, 0, 8);
    wait_done();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_d.size()), 64'h0);
    check("idle_not_busy", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
